rr_arbiter4: RTL and testbench



---
 rtl/arb_pkg.sv | 31 +++
 rtl/onehot_dec2_4.sv | 16 +
 rtl/rr_arbiter4.sv | 119 +++++++++++
 tb/tb_rr_arbiter4.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, sizes and priority search for rr_arbiter4
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Search from last+1 upward with wrap; the previous owner is checked last.
  function automatic idx_t rr_pick(input logic [NUM_REQ-1:0] req, input idx_t last);
    idx_t pick;
    logic found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_t cand;
      cand = last + idx_t'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/onehot_dec2_4.sv
// rtl/onehot_dec2_4.sv - 2-bit index plus enable to 4-bit one-hot decoder
module onehot_dec2_4
  import arb_pkg::*;
(
  input  idx_t       idx,
  input  logic       en,
  output logic [3:0] onehot
);

  // Single bit at position idx when enabled, otherwise all zero.
  always_comb begin
    onehot = 4'b0000;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - 4-way round-robin arbiter; ARB_HOLD_LIMIT_EN adds the hold limit and timeout
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD must be in 2..255");
  end

  state_t state_q, state_d;
  idx_t   idx_q, idx_d;
  idx_t   last_q, last_d;
  logic   valid_q, valid_d;

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;
`endif

  // Next-state: pick a winner in IDLE, hold it in GRANT until release (or limit).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
`ifdef ARB_HOLD_LIMIT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = rr_pick(req, last_q);
          valid_d = 1'b1;
          state_d = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d  = 8'd1;
`endif
        end
      end
      GRANT: begin
        // Release has priority over the hold limit, so no timeout on a same-cycle release.
        if (!req[idx_q]) begin
          valid_d = 1'b0;
          last_d  = idx_q;
          state_d = IDLE;
`ifdef ARB_HOLD_LIMIT_EN
          hold_d  = 8'd0;
`endif
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_q == HOLD_LIM) begin
          valid_d   = 1'b0;
          last_d    = idx_q;
          state_d   = IDLE;
          hold_d    = 8'd0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; last resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= idx_t'(NUM_REQ - 1);
      valid_q   <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      valid_q   <= valid_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

`ifdef ARB_HOLD_LIMIT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  onehot_dec2_4 u_dec (
    .idx    (idx_q),
    .en     (valid_q),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - self-checking bench for rr_arbiter4 (model honours ARB_HOLD_LIMIT_EN)
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: owner = -1 when idle
  int   m_owner;
  int   m_last;
  int   m_held;
  int   m_idx;
  bit   m_to;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_held  = 0;
    m_idx   = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step();
    bit found;
    m_to = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (!found && req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_idx   = c;
          m_held  = 1;
        end
      end
    end else if (!req[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end
`ifdef ARB_HOLD_LIMIT_EN
    else if (m_held == MAX_HOLD) begin
      m_last  = m_owner;
      m_owner = -1;
      m_to    = 1'b1;
    end
`endif
    else begin
      m_held++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("cyc_gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
    chk("cyc_valid", int'(gnt_valid), (m_owner < 0) ? 0 : 1);
    chk("cyc_timeout", int'(timeout), int'(m_to));
    if (m_owner >= 0) chk("cyc_idx", int'(gnt_idx), m_idx);
  end

  int order[5];
  int n_ten;
  int cnt;

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_timeout", int'(timeout), 0);

    // fairness: each owner releases after 3 grant cycles, then re-requests
    req = 4'b1111;
    n_ten = 0;
    cnt = 0;
    for (int cyc = 0; cyc < 60 && n_ten < 5; cyc++) begin
      tick();
      if (gnt_valid) begin
        if (cnt == 0) begin
          order[n_ten] = int'(gnt_idx);
          n_ten++;
        end
        cnt++;
        if (cnt == 3) begin
          req = 4'b1111 & ~(4'b0001 << gnt_idx);
          cnt = 0;
        end
      end else begin
        req = 4'b1111;
      end
    end
    chk("fair_tenures", n_ten, 5);
    chk("fair_0", order[0], 0);
    chk("fair_1", order[1], 1);
    chk("fair_2", order[2], 2);
    chk("fair_3", order[3], 3);
    chk("fair_4", order[4], 0);
    req = 4'b0000;
    repeat (2) tick();

    // single requester grant latency and release
    req = 4'b0100;
    tick();
    chk("single_gnt", int'(gnt), 4);
    chk("single_idx", int'(gnt_idx), 2);
    chk("single_valid", int'(gnt_valid), 1);
    req = 4'b0000;
    tick();
    chk("single_drop", int'(gnt), 0);

    // make last=1, then 0011 must wrap to requester 0
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0011;
    tick();
    chk("wrap_gnt", int'(gnt), 1);

    // requester 0 keeps holding
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("hold_gnt", int'(gnt), 1);
    end
    tick();
`ifdef ARB_HOLD_LIMIT_EN
    chk("limit_gnt", int'(gnt), 0);
    chk("limit_to", int'(timeout), 1);
    tick();
    chk("limit_next", int'(gnt), 2);
    chk("limit_to_off", int'(timeout), 0);
`else
    chk("nolimit_gnt", int'(gnt), 1);
    chk("nolimit_to", int'(timeout), 0);
    tick();
    chk("nolimit_gnt2", int'(gnt), 1);
`endif
    req = 4'b0000;
    repeat (2) tick();

    // release exactly on the MAX_HOLD cycle
    req = 4'b0001;
    repeat (MAX_HOLD) tick();
    chk("edge_gnt_held", int'(gnt), 1);
    req = 4'b0000;
    tick();
    chk("edge_gnt", int'(gnt), 0);
    chk("edge_to", int'(timeout), 0);
    tick();

    // asynchronous reset in the middle of a tenure
    req = 4'b1000;
    tick();
    chk("mid_gnt", int'(gnt), 8);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_gnt", int'(gnt), 0);
    chk("async_valid", int'(gnt_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1001;
    tick();
    chk("post_rst_gnt", int'(gnt), 1);
    req = 4'b0000;
    repeat (2) tick();

    // random traffic; the owner keeps its request for a random stretch
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      if (gnt_valid) r[gnt_idx] = ($urandom_range(0, 3) != 0);
      req = r;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
